icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 226 ++++++++++++++++++++++
 tb/tb_icache.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped instruction cache between IFetch and the memory
// controller. Lines are 16 bytes (4 x 32-bit words). A miss refills the line
// with four single-word reads issued in order 0..3. A hit responds one cycle
// after acceptance. A miss responds two cycles after the final refill beat.
//
// Build option: macro ICACHE_EN
//   defined   : cache storage present (valid/tag/data per line).
//   undefined : no storage; every request is a single-beat read of in_pc.
//
// Parameters
//   INDEX_WIDTH  line-index bits (default 6 -> 64 lines)
//   LINE_WORDS   words per line, fixed at 4
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, wins over rdy and rollback
//   rdy        in   global ready; all state holds while low
//   in_valid   in   fetch request, held until the response is taken
//   in_pc      in   word-aligned fetch address
//   out_valid  out  instruction for in_pc is on out_inst
//   out_inst   out  instruction word
//   rollback   in   ROB flush; the pending response is discarded
//   mem_req    out  word read request, held until mem_done
//   mem_addr   out  word address of the current refill beat
//   mem_done   in   one-cycle pulse, mem_data valid
//   mem_data   in   returned word
// -----------------------------------------------------------------------------
module icache #(
   parameter int INDEX_WIDTH = 6,
   parameter int LINE_WORDS  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   output logic [31:0] out_inst,
   input  logic        rollback,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data
);

   typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_e;

   localparam int CNT_W = $clog2(LINE_WORDS);

   // The address arithmetic below assumes 16-byte lines.
   if (LINE_WORDS != 4 || INDEX_WIDTH < 1 || INDEX_WIDTH > 27) begin : g_bad_params
      $error("icache: LINE_WORDS must be 4 and INDEX_WIDTH within 1..27");
   end

`ifdef ICACHE_EN
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
   localparam int               LINES     = 1 << INDEX_WIDTH;
   localparam int               TAG_W     = 28 - INDEX_WIDTH;
`else
   localparam logic [CNT_W-1:0] LAST_BEAT = '0;
`endif

   state_e            state_q, state_d;
   logic              rsp_q, rsp_d;
   logic [31:0]       out_inst_q, out_inst_d;
   logic              mem_req_q, mem_req_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              drop_q, drop_d;

`ifdef ICACHE_EN
   logic [LINES-1:0]              valid_q;
   logic [TAG_W-1:0]              tag_mem  [LINES];
   logic [LINE_WORDS-1:0][31:0]   data_mem [LINES];
   logic [LINE_WORDS-2:0][31:0]   beat_buf_q;
   logic [1:0]                    wsel_q, wsel_d;
   logic [INDEX_WIDTH-1:0]        rd_idx, fill_idx;
   logic [TAG_W-1:0]              rd_tag, fill_tag;
   logic [LINE_WORDS-1:0][31:0]   fill_line;
   logic                          hit;
   logic                          beat_we;
   logic                          install;

   assign rd_idx   = in_pc[3+INDEX_WIDTH:4];
   assign rd_tag   = in_pc[31:4+INDEX_WIDTH];
   assign hit      = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
   // During a refill mem_addr_q stays inside the line being filled, so its
   // upper bits name the destination line.
   assign fill_idx = mem_addr_q[3+INDEX_WIDTH:4];
   assign fill_tag = mem_addr_q[31:4+INDEX_WIDTH];
   // The last beat is written straight from the bus together with the buffer.
   assign fill_line = {mem_data, beat_buf_q};
`endif

   always_comb begin
      // NOTE: every next-state signal is given its hold value first, so no
      // branch can leave one unassigned and infer a latch.
      state_d    = state_q;
      rsp_d      = rsp_q;
      out_inst_d = out_inst_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      cnt_d      = cnt_q;
      drop_d     = drop_q;
`ifdef ICACHE_EN
      wsel_d     = wsel_q;
      beat_we    = 1'b0;
      install    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (rollback) begin
               rsp_d = 1'b0;
            end else if (rsp_q) begin
               // Response outstanding: out_inst holds, no new lookup.
               if (!in_valid) rsp_d = 1'b0;
            end else if (in_valid) begin
`ifdef ICACHE_EN
               if (hit) begin
                  rsp_d      = 1'b1;
                  out_inst_d = data_mem[rd_idx][in_pc[3:2]];
               end else begin
                  state_d    = REFILL;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {in_pc[31:4], 4'h0};
                  cnt_d      = '0;
                  wsel_d     = in_pc[3:2];
               end
`else
               state_d    = REFILL;
               mem_req_d  = 1'b1;
               mem_addr_d = in_pc;
               cnt_d      = '0;
`endif
            end
         end

         REFILL: begin
            // The refill always runs to completion; a flush only marks the
            // response for dropping.
            if (rollback) drop_d = 1'b1;
            if (mem_req_q && mem_done) begin
               mem_req_d = 1'b0;
               if (cnt_q == LAST_BEAT) begin
                  state_d = RESPOND;
                  cnt_d   = '0;
`ifdef ICACHE_EN
                  install    = 1'b1;
                  out_inst_d = fill_line[wsel_q];
`else
                  out_inst_d = mem_data;
`endif
               end else begin
                  cnt_d      = cnt_q + 1'b1;
                  mem_addr_d = {mem_addr_q[31:4], cnt_d, 2'b00};
`ifdef ICACHE_EN
                  beat_we    = 1'b1;
`endif
               end
            end else if (!mem_req_q) begin
               // One idle cycle after each beat, then request the next word.
               mem_req_d = 1'b1;
            end
         end

         RESPOND: begin
            state_d = IDLE;
            drop_d  = 1'b0;
            if (!drop_q && !rollback) rsp_d = 1'b1;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rsp_q      <= 1'b0;
         out_inst_q <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
`ifdef ICACHE_EN
         valid_q    <= '0;
         wsel_q     <= '0;
`endif
      end else if (rdy) begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples values from before the edge.
         state_q    <= state_d;
         rsp_q      <= rsp_d;
         out_inst_q <= out_inst_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         cnt_q      <= cnt_d;
         drop_q     <= drop_d;
`ifdef ICACHE_EN
         wsel_q     <= wsel_d;
         if (install) valid_q[fill_idx] <= 1'b1;
`endif
      end
   end

`ifdef ICACHE_EN
   // NOTE: tag/data arrays and the beat buffer have no reset; valid_q gates
   // every use of them, and leaving them unreset lets them map onto RAM.
   always_ff @(posedge clk) begin
      if (!rst && rdy) begin
         if (beat_we) beat_buf_q[cnt_q] <= mem_data;
         if (install) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= fill_line;
         end
      end
   end
`endif

   assign out_valid = rsp_q & in_valid;
   assign out_inst  = out_inst_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache -- directed self-checking bench for icache. The bench plays the
// role of IFetch and of the memory controller. It also keeps a
// transaction-level model of which lines are resident. That model gives the
// expected out_valid/out_inst/mem_req/mem_addr for every cycle, and one
// compare process checks them on each falling edge. Works for both builds
// (ICACHE_EN defined or not).
// -----------------------------------------------------------------------------
module tb_icache;

`ifdef ICACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   localparam int BEATS   = CACHE ? 4 : 1;
   localparam int RB_MID  = CACHE ? 2 : 0;   // beat at which to flush mid-refill
   localparam int RB_LAST = BEATS - 1;       // flush on the final mem_done

   logic        clk = 1'b0;
   logic        rst, rdy, in_valid, rollback, mem_done;
   logic [31:0] in_pc, mem_data;
   logic        out_valid, mem_req;
   logic [31:0] out_inst, mem_addr;

   always #5 clk = ~clk;

   icache dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .in_valid (in_valid),
      .in_pc    (in_pc),
      .out_valid(out_valid),
      .out_inst (out_inst),
      .rollback (rollback),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_done (mem_done),
      .mem_data (mem_data)
   );

   int          n_checks = 0;
   int          n_err    = 0;
   bit          chk_en   = 1'b0;
   logic        exp_ov, exp_mreq;
   logic [31:0] exp_oi, exp_maddr;

   // Resident-line model: which line address occupies each index.
   bit          mdl_v    [64];
   logic [27:0] mdl_line [64];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic bit mdl_hit(input logic [31:0] pc);
      return CACHE && mdl_v[pc[9:4]] && (mdl_line[pc[9:4]] == pc[31:4]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison against the expectations set by the driver.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         if (exp_ov) check("out_inst", out_inst, exp_oi);
         check("mem_req", 32'(mem_req), 32'(exp_mreq));
         if (exp_mreq) check("mem_addr", mem_addr, exp_maddr);
      end
   end

   // One complete fetch. rb_beat >= 0 flushes during that refill beat (in its
   // wait cycle, or on its mem_done when rb_on_done). stall_beat >= 0 drops rdy
   // for 3 cycles at the start of that beat. rb_idle flushes in the first
   // request cycle so acceptance slips by one cycle.
   task automatic fetch(input logic [31:0] pc, input int hold, input int rb_beat,
                        input bit rb_on_done, input int stall_beat, input bit rb_idle,
                        output logic [31:0] got);
      bit          hit;
      bit          drop;
      logic [31:0] base;
      hit  = mdl_hit(pc);
      base = CACHE ? {pc[31:4], 4'h0} : pc;
      drop = !hit && rb_beat >= 0 && rb_beat < BEATS;
      got  = '0;

      in_valid = 1'b1;
      in_pc    = pc;
      exp_ov   = 1'b0;
      exp_mreq = 1'b0;
      if (rb_idle) begin
         rollback = 1'b1;
         step();
         rollback = 1'b0;
      end
      step();                                   // accepting edge

      if (!hit) begin
         for (int k = 0; k < BEATS; k++) begin
            exp_mreq  = 1'b1;
            exp_maddr = base + 32'(4 * k);
            if (k == stall_beat) begin
               rdy = 1'b0;
               repeat (3) step();
               rdy = 1'b1;
            end
            if (k == rb_beat && !rb_on_done) begin
               rollback = 1'b1;
               in_valid = 1'b0;
            end
            step();                             // request waits one cycle
            rollback = 1'b0;
            mem_done = 1'b1;
            mem_data = mem_word(exp_maddr);
            if (k == rb_beat && rb_on_done) begin
               rollback = 1'b1;
               in_valid = 1'b0;
            end
            step();
            mem_done = 1'b0;
            mem_data = '0;
            rollback = 1'b0;
            exp_mreq = 1'b0;
            if (k < BEATS - 1) step();          // mandatory gap between beats
         end
         if (CACHE) begin
            mdl_v[pc[9:4]]    = 1'b1;
            mdl_line[pc[9:4]] = pc[31:4];
         end
         step();                                // RESPOND cycle
      end

      // A dropped response leaves in_valid low. If the caller re-requests
      // right away, the next cycle shows any stale rsp_q.
      if (!drop) begin
         exp_ov = 1'b1;
         exp_oi = mem_word(pc);
         for (int i = 0; i < hold; i++) begin
            if (i == 0) got = out_inst;
            step();
         end
         in_valid = 1'b0;
         exp_ov   = 1'b0;
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] got;
      rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_pc = '0;
      rollback = 1'b0; mem_done = 1'b0; mem_data = '0;
      exp_ov = 1'b0; exp_oi = '0; exp_mreq = 1'b0; exp_maddr = '0;
      for (int i = 0; i < 64; i++) mdl_v[i] = 1'b0;
      repeat (3) step();
      rst = 1'b0;

      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_inst",  out_inst,       32'd0);
      check("reset_mem_req",   32'(mem_req),   32'd0);
      check("reset_mem_addr",  mem_addr,       32'd0);
      chk_en = 1'b1;

      // Cold miss, then a hit in the same line, then a hit held by IFetch.
      fetch(32'h0000_0000, 1, -1, 1'b0, -1, 1'b0, got);
      check("cold_miss_inst", got, 32'hFFFF_0000);
      fetch(32'h0000_0008, 1, -1, 1'b0, -1, 1'b0, got);
      check("hit_0x8_inst", got, 32'hFFF7_0008);
      fetch(32'h0000_0004, 5, -1, 1'b0, -1, 1'b0, got);
      check("hold_5_inst", got, 32'hFFFB_0004);

      // Conflict on index 0 evicts line 0x0.
      fetch(32'h0000_0400, 1, -1, 1'b0, -1, 1'b0, got);
      check("evict_inst", got, 32'hFBFF_0400);
      fetch(32'h0000_0000, 1, -1, 1'b0, -1, 1'b0, got);
      check("remiss_inst", got, 32'hFFFF_0000);

      // Flush mid-refill: response dropped, line still installed.
      fetch(32'h0000_1004, 1, RB_MID, 1'b0, -1, 1'b0, got);
      fetch(32'h0000_1004, 1, -1, 1'b0, -1, 1'b0, got);
      check("after_drop_inst", got, 32'hEFFB_1004);

      // Flush coinciding with the final mem_done.
      fetch(32'h0000_2018, 1, RB_LAST, 1'b1, -1, 1'b0, got);
      fetch(32'h0000_201C, 1, -1, 1'b0, -1, 1'b0, got);
      check("last_beat_drop_inst", got, 32'hDFE3_201C);

      // rdy stall mid-refill, then a flush in the first request cycle.
      fetch(32'h0000_3028, 2, -1, 1'b0, RB_MID, 1'b0, got);
      check("stall_inst", got, 32'hCFD7_3028);
      fetch(32'h0000_3028, 1, -1, 1'b0, -1, 1'b1, got);
      check("idle_rb_inst", got, 32'hCFD7_3028);

      // Reset during a refill, with rdy low and rollback high.
      in_valid = 1'b1; in_pc = 32'h0000_5000; exp_ov = 1'b0; exp_mreq = 1'b0;
      step();
      exp_mreq = 1'b1; exp_maddr = 32'h0000_5000;
      if (CACHE) begin
         mem_done = 1'b1;
         mem_data = mem_word(32'h0000_5000);
      end
      step();
      mem_done = 1'b0; in_valid = 1'b0; rst = 1'b1; rdy = 1'b0; rollback = 1'b1;
      step();
      rst = 1'b0; rdy = 1'b1; rollback = 1'b0; exp_mreq = 1'b0;
      for (int i = 0; i < 64; i++) mdl_v[i] = 1'b0;
      check("rst_mid_mem_req",  32'(mem_req), 32'd0);
      check("rst_mid_mem_addr", mem_addr,     32'd0);
      check("rst_mid_out_inst", out_inst,     32'd0);
      fetch(32'h0000_5000, 1, -1, 1'b0, -1, 1'b0, got);
      check("post_rst_inst", got, 32'hAFFF_5000);
      fetch(32'h0000_3028, 1, -1, 1'b0, -1, 1'b0, got);
      check("post_rst_remiss_inst", got, 32'hCFD7_3028);

      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
